sdio_tx_prefetch: RTL and testbench

SDIO_TX_PREFETCH -- requirements
Module: sdio_tx_prefetch

---
 rtl/sdio_tx_prefetch.sv | 122 ++++++++++++
 tb/tb_sdio_tx_prefetch.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_tx_prefetch.sv
// uDMA -> SDIO TX prefetch FIFO. It holds data back until PREFILL words are buffered, or the whole transfer is buffered.
// Define SDIO_TX_PREFETCH_BSWAP_EN to store pushed words byte-reversed.
module sdio_tx_prefetch #(
  parameter int DEPTH   = 8,
  parameter int PREFILL = 4
) (
  input  logic                   clk_i,
  input  logic                   rstn_i,
  input  logic                   clr_i,
  input  logic                   xfer_start_i,
  input  logic [9:0]             data_block_size_i,
  input  logic [7:0]             data_block_num_i,
  input  logic [31:0]            udma_data_i,
  input  logic                   udma_valid_i,
  output logic                   udma_ready_o,
  output logic [31:0]            out_data_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] PRE_LVL  = LW'(PREFILL);

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]   level_q;
  logic [16:0]     accept_cnt_q, send_cnt_q;
  logic            done_q;
  logic [31:0]     mem [DEPTH];

  logic            push, pop, load, last_pop;
  logic            full, empty;
  logic [16:0]     words, blocks, total;
  logic [31:0]     wdata;
  logic            unused_size_lsb;

  assign unused_size_lsb = ^data_block_size_i[1:0];

  // 9-bit operands widened to 17 bits so 256*256 does not wrap
  assign words  = 17'(data_block_size_i[9:2]) + 17'd1;
  assign blocks = 17'(data_block_num_i) + 17'd1;
  assign total  = words * blocks;

  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign load     = (state_q == IDLE) & xfer_start_i & ~clr_i;
  assign push     = udma_valid_i & udma_ready_o;
  assign pop      = out_valid_o & out_ready_i;
  assign last_pop = pop & (send_cnt_q == 17'd1);

`ifdef SDIO_TX_PREFETCH_BSWAP_EN
  assign wdata = {udma_data_i[7:0], udma_data_i[15:8], udma_data_i[23:16], udma_data_i[31:24]};
`else
  assign wdata = udma_data_i;
`endif

  assign udma_ready_o = (state_q != IDLE) & ~full & (accept_cnt_q != '0);
  assign out_valid_o  = (state_q == STREAM) & ~empty;
  assign out_data_o   = out_valid_o ? mem[rd_ptr_q] : 32'h0;
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign level_o      = level_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (xfer_start_i) state_d = FILL;
      FILL:    if ((level_q >= PRE_LVL) || ((accept_cnt_q == '0) && !empty)) state_d = STREAM;
      STREAM:  if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (clr_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      accept_cnt_q <= '0;
      send_cnt_q   <= '0;
      done_q       <= 1'b0;
    end else if (clr_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      accept_cnt_q <= '0;
      send_cnt_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q <= last_pop;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
      if (load)      accept_cnt_q <= total;
      else if (push) accept_cnt_q <= accept_cnt_q - 17'd1;
      if (load)      send_cnt_q <= total;
      else if (pop)  send_cnt_q <= send_cnt_q - 17'd1;
    end
  end

  // storage carries no reset; occupancy logic guarantees no stale word is ever presented
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: tb/tb_sdio_tx_prefetch.sv
// Randomized bench for sdio_tx_prefetch against a queue-based transfer model.
module tb_sdio_tx_prefetch;
  localparam int DEPTH = 8;
  localparam int PREFILL = 4;

  logic        clk = 1'b0;
  logic        rstn, clr, start, uvalid, uready, ovalid, oready, busy, done;
  logic [9:0]  bsize;
  logic [7:0]  bnum;
  logic [31:0] udata, odata;
  logic [3:0]  level;

  always #5 clk = ~clk;

  sdio_tx_prefetch #(.DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
    .clk_i(clk), .rstn_i(rstn), .clr_i(clr), .xfer_start_i(start),
    .data_block_size_i(bsize), .data_block_num_i(bnum),
    .udma_data_i(udata), .udma_valid_i(uvalid), .udma_ready_o(uready),
    .out_data_o(odata), .out_valid_o(ovalid), .out_ready_i(oready),
    .busy_o(busy), .done_o(done), .level_o(level)
  );

  // model: 0 idle, 1 filling, 2 streaming
  int          m_st, m_acc, m_send, m_pops, n_chk, n_err, done_cnt;
  bit          m_done;
  logic [31:0] mq[$];

  function automatic logic [31:0] fmt(input logic [31:0] d);
`ifdef SDIO_TX_PREFETCH_BSWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_st = 0; m_acc = 0; m_send = 0; m_done = 0;
  endtask

  task automatic m_edge();
    int lvl, st;
    bit push, pop;
    lvl = mq.size();
    st  = m_st;
    if (clr) begin m_reset(); return; end
    push   = (st != 0) && (lvl < DEPTH) && (m_acc > 0) && uvalid;
    pop    = (st == 2) && (lvl > 0) && oready;
    m_done = 0;
    if (st == 1 && (lvl >= PREFILL || (m_acc == 0 && lvl > 0))) m_st = 2;
    if (pop) begin
      void'(mq.pop_front());
      m_send--; m_pops++;
      if (m_send == 0) begin m_st = 0; m_done = 1; end
    end
    if (push) begin mq.push_back(fmt(udata)); m_acc--; end
    if (st == 0 && start) begin
      m_acc  = (int'(bsize[9:2]) + 1) * (int'(bnum) + 1);
      m_send = m_acc;
      m_st   = 1;
    end
  endtask

  task automatic compare();
    bit er, ev;
    er = (m_st != 0) && (mq.size() < DEPTH) && (m_acc > 0);
    ev = (m_st == 2) && (mq.size() > 0);
    chk("level", 32'(level), 32'(mq.size()));
    chk("udma_ready", 32'(uready), 32'(er));
    chk("out_valid", 32'(ovalid), 32'(ev));
    chk("out_data", odata, ev ? mq[0] : 32'h0);
    chk("busy", 32'(busy), 32'(m_st != 0));
    chk("done", 32'(done), 32'(m_done));
    if (done) done_cnt++;
  endtask

  task automatic cyc(input bit c, input bit s, input bit uv, input logic [31:0] ud, input bit ordy);
    clr = c; start = s; uvalid = uv; udata = ud; oready = ordy;
    @(posedge clk);
    m_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic kick(input logic [9:0] sz, input logic [7:0] nb);
    bsize = sz; bnum = nb;
    cyc(0, 1, 0, $urandom, 0);
  endtask

  // run until the model says the transfer ended; random spurious start pulses must be ignored
  task automatic run_xfer(input int budget, input int pv, input int pr, input bit clr_en);
    int k = 0;
    while (m_st != 0 && k < budget) begin
      cyc(clr_en && ($urandom_range(0, 199) == 0), $urandom_range(0, 15) == 0,
          $urandom_range(1, 100) <= pv, $urandom, $urandom_range(1, 100) <= pr);
      k++;
    end
    chk("xfer_timeout_state", 32'(m_st), 32'd0);
  endtask

  initial begin
    int d0, p0, k;
    logic [31:0] held, exp_sw;
    n_chk = 0; n_err = 0; done_cnt = 0; m_pops = 0;
    rstn = 1'b0; clr = 0; start = 0; uvalid = 0; udata = '0; oready = 0; bsize = '0; bnum = '0;
    m_reset();
    #12;
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_uready", 32'(uready), 32'd0);
    chk("rst_ovalid", 32'(ovalid), 32'd0);
    chk("rst_odata", odata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clk); rstn = 1'b1;
    cyc(0, 0, 0, 0, 0);

    // 128 words, both sides always ready
    d0 = done_cnt; p0 = m_pops;
    kick(10'd511, 8'd0);
    k = 0;
    while (!ovalid && k < 50) begin cyc(0, 0, 1, $urandom, 1); k++; end
    chk("s34_first_valid_level", 32'(level >= PREFILL), 32'd1);
    run_xfer(1000, 100, 100, 0);
    chk("s34_words", 32'(m_pops - p0), 32'd128);
    chk("s34_done_pulses", 32'(done_cnt - d0), 32'd1);

    // 2-word transfer below PREFILL enters STREAM on accept count exhaustion
    d0 = done_cnt; p0 = m_pops;
    kick(10'd3, 8'd1);
    k = 0;
    while (!ovalid && k < 20) begin cyc(0, 0, 1, $urandom, 0); k++; end
    chk("s35_level_at_stream", 32'(level), 32'd2);
    run_xfer(100, 100, 100, 0);
    chk("s35_words", 32'(m_pops - p0), 32'd2);
    chk("s35_done_pulses", 32'(done_cnt - d0), 32'd1);

    // backpressure: 9 words offered into an 8-deep FIFO
    p0 = m_pops;
    kick(10'd35, 8'd0);
    repeat (20) cyc(0, 0, 1, $urandom, 0);
    chk("s36_level_full", 32'(level), 32'd8);
    chk("s36_uready_low", 32'(uready), 32'd0);
    held = odata;
    repeat (5) cyc(0, 0, 1, $urandom, 0);
    chk("s36_head_stable", odata, held);
    run_xfer(200, 100, 100, 0);
    chk("s36_words", 32'(m_pops - p0), 32'd9);

    // flush at level 5 with a concurrent start
    d0 = done_cnt;
    kick(10'd511, 8'd3);
    k = 0;
    while (mq.size() < 5 && k < 30) begin cyc(0, 0, 1, $urandom, 0); k++; end
    chk("s37_level5", 32'(level), 32'd5);
    cyc(1, 1, 1, $urandom, 1);
    chk("s37_busy", 32'(busy), 32'd0);
    chk("s37_level", 32'(level), 32'd0);
    chk("s37_no_done", 32'(done_cnt - d0), 32'd0);
    cyc(0, 0, 0, 0, 0);
    kick(10'd15, 8'd0);
    run_xfer(200, 80, 80, 0);
    chk("s37_restart_done", 32'(done_cnt - d0), 32'd1);

    // byte ordering of a known word
`ifdef SDIO_TX_PREFETCH_BSWAP_EN
    exp_sw = 32'h44332211;
`else
    exp_sw = 32'h11223344;
`endif
    kick(10'd3, 8'd0);
    cyc(0, 0, 1, 32'h11223344, 0);
    k = 0;
    while (!ovalid && k < 10) begin cyc(0, 0, 0, 0, 0); k++; end
    chk("s38_word", odata, exp_sw);
    run_xfer(50, 100, 100, 0);

    // start pulse with a different size while filling is ignored
    p0 = m_pops;
    kick(10'd15, 8'd0);
    cyc(0, 0, 1, $urandom, 0);
    bsize = 10'd1023; bnum = 8'd255;
    cyc(0, 1, 1, $urandom, 0);
    run_xfer(100, 100, 100, 0);
    chk("s39_fill_start_ignored", 32'(m_pops - p0), 32'd4);

    // async reset mid-STREAM
    d0 = done_cnt;
    kick(10'd511, 8'd0);
    k = 0;
    while (m_pops - p0 < 10 && k < 100) begin cyc(0, 0, 1, $urandom, 1); k++; end
    #2 rstn = 1'b0;
    #1;
    clr = 0; start = 0; uvalid = 0; oready = 0;
    m_reset();
    chk("arst_uready", 32'(uready), 32'd0);
    chk("arst_ovalid", 32'(ovalid), 32'd0);
    chk("arst_odata", odata, 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk); @(negedge clk); rstn = 1'b1;
    cyc(0, 0, 0, 0, 0);
    chk("arst_no_done", 32'(done_cnt - d0), 32'd0);

    // randomized transfers with random handshakes and occasional flush
    for (int t = 0; t < 30; t++) begin
      kick(10'($urandom_range(0, 63)), 8'($urandom_range(0, 3)));
      run_xfer(3000, $urandom_range(30, 100), $urandom_range(30, 100), 1);
      repeat ($urandom_range(0, 3)) cyc(0, 0, $urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
